// File: rtl/rv32_pkg.sv
// ---------------------------------------------------------------------------
// rv32_pkg
// Shared RV32I decode definitions used by the instruction slicer and its
// immediate generator.
//   - Major opcode values (instr[6:0]) for every legal RV32I base opcode.
//   - fmt_t: instruction format classification, with BAD for illegal opcodes.
//   - LSB and width constants for the fixed instruction fields.
// ---------------------------------------------------------------------------
package rv32_pkg;

    // Major opcodes
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_OPIMM  = 7'h13;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_OP     = 7'h33;
    localparam logic [6:0] OP_FENCE  = 7'h0F;
    localparam logic [6:0] OP_SYSTEM = 7'h73;

    // Instruction format codes
    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_SYS = 3'd6,
        FMT_BAD = 3'd7
    } fmt_t;

    // Field bit positions
    localparam int OPCODE_LSB = 0;
    localparam int OPCODE_W   = 7;
    localparam int RD_LSB     = 7;
    localparam int REG_W      = 5;
    localparam int FUNCT3_LSB = 12;
    localparam int FUNCT3_W   = 3;
    localparam int RS1_LSB    = 15;
    localparam int RS2_LSB    = 20;
    localparam int FUNCT7_LSB = 25;
    localparam int FUNCT7_W   = 7;
    localparam int CSR_LSB    = 20;
    localparam int CSR_ADDR_W = 12;

endpackage

// File: rtl/instr_slicer_imm_gen.sv
// ---------------------------------------------------------------------------
// imm_gen
// Builds every RV32I immediate from a raw instruction word. All outputs are
// sign-extended (or, for U-type, placed in the upper bits) to XLEN.
//   instr  in   32    raw instruction word
//   imm_i  out  XLEN  I-type immediate
//   imm_s  out  XLEN  S-type immediate
//   imm_b  out  XLEN  B-type immediate (bit 0 always 0)
//   imm_u  out  XLEN  U-type immediate (low 12 bits 0)
//   imm_j  out  XLEN  J-type immediate (bit 0 always 0)
// ---------------------------------------------------------------------------
module imm_gen
    import rv32_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm_i,
    output logic [XLEN-1:0] imm_s,
    output logic [XLEN-1:0] imm_b,
    output logic [XLEN-1:0] imm_u,
    output logic [XLEN-1:0] imm_j
);

    // Raw immediates are held as signed values so that the width casts
    // below sign-extend them to XLEN.
    logic signed [11:0] raw_i;
    logic signed [11:0] raw_s;
    logic signed [12:0] raw_b;
    logic signed [31:0] raw_u;
    logic signed [20:0] raw_j;

    assign raw_i = instr[31:20];
    assign raw_s = {instr[31:25], instr[11:7]};
    assign raw_b = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign raw_u = {instr[31:12], 12'h000};
    assign raw_j = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    assign imm_i = XLEN'(raw_i);
    assign imm_s = XLEN'(raw_s);
    assign imm_b = XLEN'(raw_b);
    assign imm_u = XLEN'(raw_u);
    assign imm_j = XLEN'(raw_j);

endmodule

// File: rtl/instr_slicer.sv
// ---------------------------------------------------------------------------
// instr_slicer
// Decode-stage field extractor for RV32I. Splits the instruction into its
// fixed fields, decodes all immediates, classifies the format and keeps a
// sticky record of any illegal opcode seen since reset.
//   clk           in   1      rising-edge clock
//   rst           in   1      synchronous active-high reset (flag only)
//   instr         in   32     instruction word
//   opcode        out  7      instr[6:0]
//   rd            out  5      instr[11:7]
//   funct3        out  3      instr[14:12]
//   rs1           out  5      instr[19:15]
//   rs2           out  5      instr[24:20]
//   funct7        out  7      instr[31:25]
//   shamt         out  5      instr[24:20]
//   csr           out  CSR_W  instr[31:20], zero-extended
//   imm_i..imm_j  out  XLEN   decoded immediates
//   fmt           out  3      format code (fmt_t)
//   illegal       out  1      current opcode is not legal
//   illegal_seen  out  1      sticky illegal flag, cleared by rst
// ---------------------------------------------------------------------------
module instr_slicer
    import rv32_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CSR_W = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr,
    output logic [6:0]       opcode,
    output logic [4:0]       rd,
    output logic [2:0]       funct3,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [6:0]       funct7,
    output logic [4:0]       shamt,
    output logic [CSR_W-1:0] csr,
    output logic [XLEN-1:0]  imm_i,
    output logic [XLEN-1:0]  imm_s,
    output logic [XLEN-1:0]  imm_b,
    output logic [XLEN-1:0]  imm_u,
    output logic [XLEN-1:0]  imm_j,
    output logic [2:0]       fmt,
    output logic             illegal,
    output logic             illegal_seen
);

    fmt_t fmt_d;

    // Raw field taps; driven for every format, legal or not.
    assign opcode = instr[OPCODE_LSB +: OPCODE_W];
    assign rd     = instr[RD_LSB     +: REG_W];
    assign funct3 = instr[FUNCT3_LSB +: FUNCT3_W];
    assign rs1    = instr[RS1_LSB    +: REG_W];
    assign rs2    = instr[RS2_LSB    +: REG_W];
    assign funct7 = instr[FUNCT7_LSB +: FUNCT7_W];
    assign shamt  = instr[RS2_LSB    +: REG_W];
    assign csr    = CSR_W'(instr[CSR_LSB +: CSR_ADDR_W]);

    imm_gen #(
        .XLEN (XLEN)
    ) u_imm_gen (
        .instr (instr),
        .imm_i (imm_i),
        .imm_s (imm_s),
        .imm_b (imm_b),
        .imm_u (imm_u),
        .imm_j (imm_j)
    );

    // Opcode classification; anything outside the base set is BAD.
    always_comb begin
        fmt_d = FMT_BAD;
        case (instr[OPCODE_LSB +: OPCODE_W])
            OP_OP:                                fmt_d = FMT_R;
            OP_LOAD, OP_OPIMM, OP_JALR, OP_FENCE: fmt_d = FMT_I;
            OP_STORE:                             fmt_d = FMT_S;
            OP_BRANCH:                            fmt_d = FMT_B;
            OP_LUI, OP_AUIPC:                     fmt_d = FMT_U;
            OP_JAL:                               fmt_d = FMT_J;
            OP_SYSTEM:                            fmt_d = FMT_SYS;
            default:                              fmt_d = FMT_BAD;
        endcase
    end

    assign fmt     = fmt_d;
    assign illegal = (fmt_d == FMT_BAD);

    // Sticky flag: reset takes priority over a simultaneous illegal opcode.
    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_seen <= 1'b0;
        end else if (illegal) begin
            illegal_seen <= 1'b1;
        end
    end

endmodule

// File: tb/tb_instr_slicer.sv
// ---------------------------------------------------------------------------
// tb_instr_slicer
// Drives instruction words into instr_slicer, pushes the expected response
// from a reference model into a scoreboard queue, and a separate monitor
// pops and compares on every falling clock edge.
// ---------------------------------------------------------------------------
module tb_instr_slicer;

    localparam int XLEN  = 32;
    localparam int CSR_W = 20;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] opcode;
        logic [31:0] rd;
        logic [31:0] funct3;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] funct7;
        logic [31:0] csr;
        logic [31:0] imm_i;
        logic [31:0] imm_s;
        logic [31:0] imm_b;
        logic [31:0] imm_u;
        logic [31:0] imm_j;
        logic [31:0] fmt;
        logic        illegal;
        logic        seen;
    } exp_t;

    logic             clk;
    logic             rst;
    logic [31:0]      instr;
    logic [6:0]       opcode;
    logic [4:0]       rd;
    logic [2:0]       funct3;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [6:0]       funct7;
    logic [4:0]       shamt;
    logic [CSR_W-1:0] csr;
    logic [XLEN-1:0]  imm_i;
    logic [XLEN-1:0]  imm_s;
    logic [XLEN-1:0]  imm_b;
    logic [XLEN-1:0]  imm_u;
    logic [XLEN-1:0]  imm_j;
    logic [2:0]       fmt;
    logic             illegal;
    logic             illegal_seen;

    exp_t sb[$];
    int   tests  = 0;
    int   errors = 0;

    int   fmt_of[int];
    logic seen_model;
    logic cur_rst;
    logic [31:0] cur_instr;

    instr_slicer #(
        .XLEN  (XLEN),
        .CSR_W (CSR_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .instr        (instr),
        .opcode       (opcode),
        .rd           (rd),
        .funct3       (funct3),
        .rs1          (rs1),
        .rs2          (rs2),
        .funct7       (funct7),
        .shamt        (shamt),
        .csr          (csr),
        .imm_i        (imm_i),
        .imm_s        (imm_s),
        .imm_b        (imm_b),
        .imm_u        (imm_u),
        .imm_j        (imm_j),
        .fmt          (fmt),
        .illegal      (illegal),
        .illegal_seen (illegal_seen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Legal opcode -> format table (R=0 I=1 S=2 B=3 U=4 J=5 SYS=6).
    function automatic void initTable();
        fmt_of[32'h33] = 0;
        fmt_of[32'h03] = 1;
        fmt_of[32'h13] = 1;
        fmt_of[32'h67] = 1;
        fmt_of[32'h0F] = 1;
        fmt_of[32'h23] = 2;
        fmt_of[32'h63] = 3;
        fmt_of[32'h37] = 4;
        fmt_of[32'h17] = 4;
        fmt_of[32'h6F] = 5;
        fmt_of[32'h73] = 6;
    endfunction

    function automatic bit isIllegal(input logic [31:0] w);
        return !fmt_of.exists(int'(w & 32'h7F));
    endfunction

    function automatic int bitOf(input logic [31:0] w, input int pos);
        return int'((w >> pos) & 32'h1);
    endfunction

    // Reference model: immediates built from signed arithmetic on bit groups.
    function automatic exp_t model(input logic [31:0] w, input logic seen);
        exp_t e;
        int   op;
        int   sign;
        e.instr  = w;
        op       = int'(w & 32'h7F);
        e.opcode = w & 32'h7F;
        e.rd     = (w >> 7)  & 32'h1F;
        e.funct3 = (w >> 12) & 32'h7;
        e.rs1    = (w >> 15) & 32'h1F;
        e.rs2    = (w >> 20) & 32'h1F;
        e.funct7 = (w >> 25) & 32'h7F;
        e.csr    = (w >> 20) & 32'hFFF;
        sign     = bitOf(w, 31);
        e.imm_i  = 32'(-sign * 2048 + int'((w >> 20) & 32'h7FF));
        e.imm_s  = 32'(-sign * 2048 + int'((w >> 25) & 32'h3F) * 32 + int'((w >> 7) & 32'h1F));
        e.imm_b  = 32'(-sign * 4096 + bitOf(w, 7) * 2048 + int'((w >> 25) & 32'h3F) * 32
                       + int'((w >> 8) & 32'hF) * 2);
        e.imm_u  = w & 32'hFFFFF000;
        e.imm_j  = 32'(-sign * 1048576 + int'((w >> 12) & 32'hFF) * 4096 + bitOf(w, 20) * 2048
                       + int'((w >> 21) & 32'h3FF) * 2);
        if (fmt_of.exists(op)) begin
            e.fmt     = 32'(fmt_of[op]);
            e.illegal = 1'b0;
        end else begin
            e.fmt     = 32'd7;
            e.illegal = 1'b1;
        end
        e.seen = seen;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] w,
                               input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s instr=%h got=%h expected=%h", name, w, act, exp);
        end
    endtask

    // One cycle: account for the edge using the previous inputs, then apply
    // new inputs and queue the expected response.
    task automatic applyStimulus(input logic r, input logic [31:0] w);
        @(posedge clk);
        if (cur_rst) seen_model = 1'b0;
        else if (isIllegal(cur_instr)) seen_model = 1'b1;
        #1;
        rst       = r;
        instr     = w;
        cur_rst   = r;
        cur_instr = w;
        sb.push_back(model(w, seen_model));
    endtask

    // Monitor: compares whatever the scoreboard holds against the DUT.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput("opcode",  e.instr, 32'(opcode),  e.opcode);
                checkOutput("rd",      e.instr, 32'(rd),      e.rd);
                checkOutput("funct3",  e.instr, 32'(funct3),  e.funct3);
                checkOutput("rs1",     e.instr, 32'(rs1),     e.rs1);
                checkOutput("rs2",     e.instr, 32'(rs2),     e.rs2);
                checkOutput("funct7",  e.instr, 32'(funct7),  e.funct7);
                checkOutput("shamt",   e.instr, 32'(shamt),   e.rs2);
                checkOutput("csr",     e.instr, 32'(csr),     e.csr);
                checkOutput("imm_i",   e.instr, imm_i,        e.imm_i);
                checkOutput("imm_s",   e.instr, imm_s,        e.imm_s);
                checkOutput("imm_b",   e.instr, imm_b,        e.imm_b);
                checkOutput("imm_u",   e.instr, imm_u,        e.imm_u);
                checkOutput("imm_j",   e.instr, imm_j,        e.imm_j);
                checkOutput("fmt",     e.instr, 32'(fmt),     e.fmt);
                checkOutput("illegal", e.instr, 32'(illegal), 32'(e.illegal));
                checkOutput("illegal_seen", e.instr, 32'(illegal_seen), 32'(e.seen));
            end
        end
    end

    // Driver
    initial begin
        logic [31:0] w;
        logic [6:0]  legal_ops[11];
        int          wait_cycles;
        legal_ops = '{7'h33, 7'h03, 7'h13, 7'h67, 7'h0F, 7'h23,
                      7'h63, 7'h37, 7'h17, 7'h6F, 7'h73};
        initTable();
        seen_model = 1'b0;
        rst        = 1'b1;
        instr      = 32'h0000_0013;
        cur_rst    = 1'b1;
        cur_instr  = 32'h0000_0013;

        // Reset, then the sticky-flag sequence.
        applyStimulus(1'b1, 32'h0000_0013);
        applyStimulus(1'b1, 32'h0000_0013);
        applyStimulus(1'b0, 32'h0000_007F);
        applyStimulus(1'b0, 32'h0000_0013);
        applyStimulus(1'b0, 32'h403100B3);
        applyStimulus(1'b1, 32'h0000_007F);
        applyStimulus(1'b0, 32'h0000_0013);

        // Directed decodes.
        applyStimulus(1'b0, 32'h403100B3);
        applyStimulus(1'b0, 32'h00C0D393);
        applyStimulus(1'b0, 32'hABC19273);
        applyStimulus(1'b0, 32'h123450B7);
        applyStimulus(1'b0, 32'hFE112E23);
        applyStimulus(1'b0, 32'hFE0008E3);
        applyStimulus(1'b0, 32'h8000006F);
        applyStimulus(1'b0, 32'h0000_0000);
        applyStimulus(1'b0, 32'hFFFF_FFFF);

        // Random words: half with a forced legal opcode, occasional reset.
        for (int i = 0; i < 200; i++) begin
            w = $urandom;
            if ($urandom_range(1) == 1) w[6:0] = legal_ops[$urandom_range(10)];
            applyStimulus(($urandom_range(19) == 0), w);
        end

        wait_cycles = 0;
        while (sb.size() > 0 && wait_cycles < 20) begin
            @(posedge clk);
            wait_cycles++;
        end
        tests++;
        if (sb.size() > 0) begin
            errors++;
            $display("[TB] FAIL drain pending=%0d required=0", sb.size());
        end
        @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
